// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-style interrupt sequencer.
package pic_pkg;

    localparam int         N_IRQ          = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_e;

    localparam logic [1:0] INTA_CNT_IDLE   = 2'd0;
    localparam logic [1:0] INTA_CNT_FIRST  = 2'd1;
    localparam logic [1:0] INTA_CNT_VECTOR = 2'd2;

    // Distance of a level from the current top-priority slot; 0 = highest priority.
    function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: slot (lowest+1)%8 is highest, lowest is last.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [N_IRQ-1:0] vec,
    input  logic [2:0]       lowest,
    output logic             valid,
    output logic [2:0]       level
);

    logic [N_IRQ-1:0] rot;
    logic [2:0]       offset;

    // rot[0] is the highest-priority request after rotation.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_rot
        assign rot[gi] = vec[3'(lowest + 3'(gi + 1))];
    end

    always_comb begin
        offset = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 3'(i);
            end
        end
        valid = |rot;
        level = lowest + 3'd1 + offset;
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// Priority resolution, INT generation, two-pulse INTA sequencing and ISR/rotation
// bookkeeping for the 8259A-style PIC.
module pic_int_sequencer
    import pic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] IRR_status,
    input  logic [N_IRQ-1:0] IMR,
    input  logic [4:0]       ICW2_base,
    input  logic             rotate_mode,
    input  logic             AEOI,
    input  logic             INTA_pulse,
    input  logic             EOI,
    input  logic             SEOI,
    input  logic [2:0]       SEOI_level,
    output logic             INT,
    output logic [1:0]       INTA_count,
    output logic [2:0]       current_service_INT,
    output logic [N_IRQ-1:0] ISR,
    output logic [7:0]       vector,
    output logic             vector_valid
);

    pic_state_e       state_q, state_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [2:0]       lowest_q, lowest_d;
    logic [2:0]       cur_q, cur_d;
    logic [7:0]       vector_q, vector_d;

    logic [N_IRQ-1:0] cand;
    logic             win_valid, isr_valid, eligible;
    logic [2:0]       win_level, isr_level;
    logic [N_IRQ-1:0] isr_set, aeoi_clr, eoi_clr, seoi_clr;

    assign cand = IRR_status & ~IMR;

    pic_priority_resolver u_cand_res (
        .vec    (cand),
        .lowest (lowest_q),
        .valid  (win_valid),
        .level  (win_level)
    );

    pic_priority_resolver u_isr_res (
        .vec    (isr_q),
        .lowest (lowest_q),
        .valid  (isr_valid),
        .level  (isr_level)
    );

    // Fully nested: only a strictly higher level than the one in service may interrupt.
    assign eligible = win_valid &&
                      (!isr_valid || (prio_rank(win_level, lowest_q) < prio_rank(isr_level, lowest_q)));

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        vector_d = vector_q;
        lowest_d = lowest_q;
        isr_set  = '0;
        aeoi_clr = '0;
        eoi_clr  = '0;
        seoi_clr = '0;

        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (INTA_pulse) begin
                    state_d = ACK1;
                    if (win_valid) begin
                        cur_d              = win_level;
                        isr_set[win_level] = 1'b1;
                    end else begin
                        cur_d = SPURIOUS_LEVEL;
                    end
                end
            end
            ACK1: begin
                if (INTA_pulse) begin
                    state_d  = ACK2;
                    vector_d = {ICW2_base, cur_q};
                end
            end
            ACK2: begin
                state_d = IDLE;
                if (AEOI) begin
                    aeoi_clr[cur_q] = 1'b1;
                    if (rotate_mode) begin
                        lowest_d = cur_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Non-specific EOI looks at the ISR from before this cycle; SEOI takes precedence.
        if (SEOI) begin
            seoi_clr[SEOI_level] = 1'b1;
        end else if (EOI && isr_valid) begin
            eoi_clr[isr_level] = 1'b1;
            if (rotate_mode) begin
                lowest_d = isr_level;
            end
        end

        isr_d = (isr_q & ~(eoi_clr | seoi_clr | aeoi_clr)) | (isr_set & ~seoi_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            isr_q    <= '0;
            lowest_q <= 3'd7;
            cur_q    <= '0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            isr_q    <= isr_d;
            lowest_q <= lowest_d;
            cur_q    <= cur_d;
            vector_q <= vector_d;
        end
    end

    assign INT                 = (state_q == REQ);
    assign INTA_count          = (state_q == ACK1) ? INTA_CNT_FIRST :
                                 (state_q == ACK2) ? INTA_CNT_VECTOR : INTA_CNT_IDLE;
    assign vector_valid        = (state_q == ACK2);
    assign current_service_INT = cur_q;
    assign ISR                 = isr_q;
    assign vector              = vector_q;

endmodule
